// File: rtl/shift_reg_piso_tx_pkg.sv
// Shared definitions for the PISO transmitter: FSM state encoding and
// parameter-legality checks usable by the transmitter and its receiver.

`ifndef SHIFT_REG_PISO_TX_PKG_MACROS
`define SHIFT_REG_PISO_TX_PKG_MACROS

// Expand inside a module body (generate scope) to reject illegal parameters.
`define PISO_CHECK_WIDTH(w) \
  if ((w) < 2) begin : g_bad_width \
    $error("shift_reg_piso_tx: WIDTH must be >= 2"); \
  end

`define PISO_CHECK_CLKS_PER_BIT(c) \
  if ((c) < 1) begin : g_bad_clks_per_bit \
    $error("shift_reg_piso_tx: CLKS_PER_BIT must be >= 1"); \
  end

`endif

package shift_reg_piso_tx_pkg;

  // 1-bit state encoding
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Counter width able to hold the value max_val.
  function automatic int piso_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/shift_reg_piso_tx_if.sv
// Handshake and serial-output bundle of the PISO transmitter.
// master: the producer / serial consumer side; slave: the transmitter.

interface shift_reg_piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sof;
  logic             busy;
  logic             done;

  modport master (
    output d, load_valid,
    input  load_ready, sout, sout_valid, sof, busy, done
  );

  modport slave (
    input  d, load_valid,
    output load_ready, sout, sout_valid, sof, busy, done
  );
endinterface

// File: rtl/shift_reg_piso_tx_bit_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each bit period. Held at zero while clear is high, so the first period
// after clear is released is a full CLKS_PER_BIT clocks long.

module bit_tick_gen
  import shift_reg_piso_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = piso_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  `PISO_CHECK_CLKS_PER_BIT(CLKS_PER_BIT)

  logic [CW-1:0] cyc_cnt;

  assign tick = (cyc_cnt == TC);

  // Cycle counter: restarts on clear or at terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
    end else if (clear || tick) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter. A word accepted in IDLE is shifted
// out one bit per CLKS_PER_BIT clocks; sof marks the first bit period and
// done pulses in the first IDLE cycle after the last bit period.

module shift_reg_piso_tx
  import shift_reg_piso_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MSB_FIRST    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_reg_piso_tx_if.slave    tx
);

  localparam int BW = piso_cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  `PISO_CHECK_WIDTH(WIDTH)

  piso_state_e      state_q, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_nxt;
  logic             done_q, done_nxt;
  logic             bit_tick;
  logic             out_bit;

  // The timer only runs while shifting; in IDLE it sits at zero.
  bit_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != ST_SHIFT),
    .tick    (bit_tick)
  );

  // State, shift register, bit counter and done pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      shift_q   <= shift_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      done_q    <= done_nxt;
    end
  end

  // Next-state and datapath decode; d and load_valid only matter in IDLE.
  always_comb begin
    state_nxt   = state_q;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt_q;
    done_nxt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx.load_valid) begin
          state_nxt   = ST_SHIFT;
          shift_nxt   = tx.d;
          bit_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_tick) begin
          if (MSB_FIRST != 0) begin
            shift_nxt = {shift_q[WIDTH-2:0], 1'b0};
          end else begin
            shift_nxt = {1'b0, shift_q[WIDTH-1:1]};
          end
          if (bit_cnt_q == LAST_BIT) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = '0;
            done_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_bit       = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];

  // Outputs decode only from registered state, never from load_valid or d.
  assign tx.load_ready = (state_q == ST_IDLE);
  assign tx.busy       = (state_q == ST_SHIFT);
  assign tx.sout_valid = (state_q == ST_SHIFT);
  assign tx.sof        = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
  assign tx.sout       = (state_q == ST_SHIFT) && out_bit;
  assign tx.done       = done_q;

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Directed bench for shift_reg_piso_tx. Three instances cover MSB-first,
// LSB-first and a 3-clock bit period. Expected {sof, sout} pairs are queued
// when a word is offered and popped as the transmitter produces bits.

module tb_shift_reg_piso_tx;

  logic       clk;
  logic       reset_n;
  logic [7:0] d_v  [3];
  logic       lv_v [3];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [1:0] exp_q [$];

  shift_reg_piso_tx_if #(.WIDTH(8)) if0 ();
  shift_reg_piso_tx_if #(.WIDTH(8)) if1 ();
  shift_reg_piso_tx_if #(.WIDTH(8)) if2 ();

  assign if0.d = d_v[0];
  assign if0.load_valid = lv_v[0];
  assign if1.d = d_v[1];
  assign if1.load_valid = lv_v[1];
  assign if2.d = d_v[2];
  assign if2.load_valid = lv_v[2];

  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1), .CLKS_PER_BIT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .tx(if0));
  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(0), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .tx(if1));
  shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1), .CLKS_PER_BIT(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .tx(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic sample(input int u, output logic so, output logic sv, output logic sf,
                        output logic bz, output logic dn, output logic lr);
    case (u)
      0: begin so = if0.sout; sv = if0.sout_valid; sf = if0.sof; bz = if0.busy; dn = if0.done; lr = if0.load_ready; end
      1: begin so = if1.sout; sv = if1.sout_valid; sf = if1.sof; bz = if1.busy; dn = if1.done; lr = if1.load_ready; end
      default: begin so = if2.sout; sv = if2.sout_valid; sf = if2.sof; bz = if2.busy; dn = if2.done; lr = if2.load_ready; end
    endcase
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offer word w in the current (ready) cycle, follow the frame through its
  // done cycle. During the frame d is driven to d_during and load_valid to
  // hold_lv, both of which must be ignored.
  task automatic do_frame(input int u, input logic [7:0] w, input bit msb, input int cpb,
                          input bit hold_lv, input logic [7:0] d_during);
    logic so, sv, sf, bz, dn, lr;
    logic [1:0] e;
    sample(u, so, sv, sf, bz, dn, lr);
    check("ready_before_load", {7'd0, lr}, 8'd1);
    for (int n = 0; n < 8; n++) begin
      for (int c = 0; c < cpb; c++) begin
        exp_q.push_back({(n == 0), (msb ? w[7-n] : w[n])});
      end
    end
    d_v[u]  = w;
    lv_v[u] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8 * cpb; i++) begin
      sample(u, so, sv, sf, bz, dn, lr);
      check("frame_sout_valid", {7'd0, sv}, 8'd1);
      check("frame_busy", {7'd0, bz}, 8'd1);
      check("frame_ready_low", {7'd0, lr}, 8'd0);
      check("frame_no_done", {7'd0, dn}, 8'd0);
      check("scoreboard_has_entry", {7'd0, (exp_q.size() != 0)}, 8'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sout_bit", {7'd0, so}, {7'd0, e[0]});
        check("sof_flag", {7'd0, sf}, {7'd0, e[1]});
      end
      if (i == 0) begin
        d_v[u]  = d_during;
        lv_v[u] = hold_lv;
      end
      @(negedge clk);
    end
    sample(u, so, sv, sf, bz, dn, lr);
    check("done_pulse", {7'd0, dn}, 8'd1);
    check("done_cycle_sout_valid", {7'd0, sv}, 8'd0);
    check("done_cycle_ready", {7'd0, lr}, 8'd1);
    check("done_cycle_busy", {7'd0, bz}, 8'd0);
    check("scoreboard_drained", exp_q.size()[7:0], 8'd0);
  endtask

  task automatic idle_check(input int u);
    logic so, sv, sf, bz, dn, lr;
    @(negedge clk);
    sample(u, so, sv, sf, bz, dn, lr);
    check("done_single_cycle", {7'd0, dn}, 8'd0);
    check("idle_sout_valid", {7'd0, sv}, 8'd0);
    check("idle_sout", {7'd0, so}, 8'd0);
  endtask

  initial begin
    logic so, sv, sf, bz, dn, lr;
    reset_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      d_v[u]  = 8'h00;
      lv_v[u] = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Reset values
    sample(0, so, sv, sf, bz, dn, lr);
    check("rst_ready", {7'd0, lr}, 8'd1);
    check("rst_sout_valid", {7'd0, sv}, 8'd0);
    check("rst_busy", {7'd0, bz}, 8'd0);
    check("rst_done", {7'd0, dn}, 8'd0);
    check("rst_sout", {7'd0, so}, 8'd0);
    check("rst_sof", {7'd0, sf}, 8'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frames: MSB-first, LSB-first, 3 clocks per bit
    do_frame(0, 8'hC1, 1'b1, 1, 1'b0, 8'h3C);
    idle_check(0);
    do_frame(1, 8'hC1, 1'b0, 1, 1'b0, 8'h00);
    idle_check(1);
    do_frame(2, 8'hA0, 1'b1, 3, 1'b0, 8'h00);
    idle_check(2);

    // Disturbance during 8'h5A, then back-to-back FF and 00 with valid held
    do_frame(0, 8'h5A, 1'b1, 1, 1'b1, 8'hFF);
    do_frame(0, 8'hFF, 1'b1, 1, 1'b1, 8'h00);
    do_frame(0, 8'h00, 1'b1, 1, 1'b0, 8'h00);
    idle_check(0);

    // Reset in the middle of a frame of 8'hFF
    d_v[0]  = 8'hFF;
    lv_v[0] = 1'b1;
    @(negedge clk);
    lv_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(0, so, sv, sf, bz, dn, lr);
      check("pre_reset_sout", {7'd0, so}, 8'd1);
      @(negedge clk);
    end
    sample(0, so, sv, sf, bz, dn, lr);
    check("pre_reset_busy", {7'd0, bz}, 8'd1);
    #2 reset_n = 1'b0;
    #1;
    sample(0, so, sv, sf, bz, dn, lr);
    check("abort_sout_valid", {7'd0, sv}, 8'd0);
    check("abort_busy", {7'd0, bz}, 8'd0);
    check("abort_ready", {7'd0, lr}, 8'd1);
    check("abort_sout", {7'd0, so}, 8'd0);
    check("abort_done", {7'd0, dn}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample(0, so, sv, sf, bz, dn, lr);
      check("abort_no_done", {7'd0, dn}, 8'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    sample(0, so, sv, sf, bz, dn, lr);
    check("post_reset_no_done", {7'd0, dn}, 8'd0);
    do_frame(0, 8'h96, 1'b1, 1, 1'b0, 8'h00);
    idle_check(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
